bcp_scan_unit: RTL and testbench
================================

# bcp_scan_unit

Parametrised clause-scanning boolean-constraint-propagation unit for the hardware SAT datapath. It holds a loadable clause store of CLAUSE_NUM clauses over VAR_NUM variables. On request it scans the enabled clauses against a snapshot of the current partial assignment, one clause per cycle. It reports the first conflict, or otherwise the first unit clause with its implied variable and value, to the decision/backtrack controller.

## Interface
- VAR_NUM, 8, number of variables; VAR_W = max(1,$clog2(VAR_NUM))
- CLAUSE_NUM, 8, number of clause slots; CL_W = max(1,$clog2(CLAUSE_NUM))

- clock  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_en  in  1  write one clause slot
- load_addr  in  CL_W  slot index written
- load_mask  in  VAR_NUM  bit v=1: variable v appears in clause
- load_pol  in  VAR_NUM  bit v: literal polarity (1 = positive, 0 = negated)
- start  in  1  scan request
- clause_en  in  CLAUSE_NUM  per-clause enable, sampled at start
- assigned  in  VAR_NUM  variable-assigned flags, sampled at start
- value  in  VAR_NUM  assigned values, sampled at start
- busy  out  1  scan in progress
- done  out  1  one-cycle completion pulse
- result  out  2  00 none, 01 unit, 10 conflict
- imp_var  out  VAR_W  implied variable index (valid when result=01)
- imp_val  out  1  implied value (valid when result=01)
- clause_idx  out  CL_W  index of the reporting clause (result≠00)

## Operation
- FSM states: IDLE, SCAN, DONE. Reset → IDLE.
- IDLE: start=1 → snapshot clause_en/assigned/value, clear scan-local best-result, idx=0, busy=1 → SCAN.
- SCAN: evaluate clause idx. Literal v is true when mask[v]&assigned[v]&(value[v]==pol[v]). Literal v is free when mask[v]&~assigned[v].
  - Satisfied = any true literal. Otherwise free count 0 → conflict; free count 1 → unit (imp_var = the free index, imp_val = pol of it); ≥2 → nothing.
  - Disabled clause: skipped, still consumes its cycle.
  - Enabled empty clause (mask=0): conflict.
  - Priority: conflict beats unit; lower index beats higher within a class. The first unit found is kept; a later conflict overrides it.
  - idx==CLAUSE_NUM-1 → DONE; else idx+1.
- DONE: done=1 for one cycle, busy=0, result/imp_var/imp_val/clause_idx registered → IDLE. Outputs hold until the next accepted start.
- load_en is honoured only in IDLE and DONE; it is ignored while busy. Load and start in the same IDLE cycle: the load is written first, and the scan uses the new contents.
- start while busy is ignored.

## Timing
- Reset values: busy 0, done 0, result 00, imp_var 0, imp_val 0, clause_idx 0. All clause masks and polarities are cleared to 0.
- Reset mid-scan aborts immediately; no done pulse.
- Full scan: start sampled at edge E0; done high in the cycle after edge E(CLAUSE_NUM+1)-1, i.e. CLAUSE_NUM+1 edges after E0; busy is high for exactly CLAUSE_NUM cycles.
- A start in the DONE cycle is ignored; the earliest restart is the following IDLE cycle.
- Inputs assigned/value/clause_en may change freely after the start edge.

## Configuration
- BCP_SCAN_EARLY_EXIT_EN defined: SCAN jumps to DONE in the cycle after the first conflict. Done arrives k+2 edges after start for a conflict at clause k.
- Undefined: every scan always runs all CLAUSE_NUM clauses, and latency is fixed.

## Test plan
- Reset, then load clause 0 = (x0 ∨ ¬x1), clause_en=0x01, assigned=0x01, value=0x00, start → done at CLAUSE_NUM+1 edges, result=01, imp_var=1, imp_val=0, clause_idx=0.
- Clause 2 all literals false, clause 4 unit; start → result=10, clause_idx=2. With the macro, done 4 edges after start; without it, 9 edges.
- Unit at clause 1 and conflict at clause 5 → result=10, clause_idx=5.
- Every enabled clause satisfied or with ≥2 free literals → result=00, imp_var holds 0 after reset.
- Enabled unloaded slot 7 (mask 0) → conflict, clause_idx=7. With clause_en[7]=0 → result=00.
- Assert reset at cycle 3 of a scan → busy=0, no done, outputs 0, clause store cleared. start while busy is ignored. load while busy is ignored (verify by a readback scan).

Source files
------------

// File: rtl/bcp_scan_if.sv
// bcp_scan_if: clause-load, scan-request and scan-result bundle for bcp_scan_unit.
interface bcp_scan_if #(
    parameter int VAR_NUM    = 8,
    parameter int CLAUSE_NUM = 8
);
    localparam int VAR_W = (VAR_NUM > 1) ? $clog2(VAR_NUM) : 1;
    localparam int CL_W  = (CLAUSE_NUM > 1) ? $clog2(CLAUSE_NUM) : 1;
    logic                  load_en;
    logic [CL_W-1:0]       load_addr;
    logic [VAR_NUM-1:0]    load_mask;
    logic [VAR_NUM-1:0]    load_pol;
    logic                  start;
    logic [CLAUSE_NUM-1:0] clause_en;
    logic [VAR_NUM-1:0]    assigned;
    logic [VAR_NUM-1:0]    value;
    logic                  busy;
    logic                  done;
    logic [1:0]            result;
    logic [VAR_W-1:0]      imp_var;
    logic                  imp_val;
    logic [CL_W-1:0]       clause_idx;
    modport master (
        output load_en, load_addr, load_mask, load_pol, start, clause_en, assigned, value,
        input  busy, done, result, imp_var, imp_val, clause_idx
    );
    modport slave (
        input  load_en, load_addr, load_mask, load_pol, start, clause_en, assigned, value,
        output busy, done, result, imp_var, imp_val, clause_idx
    );
endinterface

// File: rtl/bcp_scan_unit.sv
// bcp_scan_unit: one-clause-per-cycle BCP scan reporting first conflict or first unit clause.
// Define BCP_SCAN_EARLY_EXIT_EN to stop the scan right after the first conflict.
module bcp_scan_unit #(
    parameter int VAR_NUM    = 8,
    parameter int CLAUSE_NUM = 8
) (
    input logic       clock,
    input logic       reset,
    bcp_scan_if.slave bus
);
    localparam int VAR_W = (VAR_NUM > 1) ? $clog2(VAR_NUM) : 1;
    localparam int CL_W  = (CLAUSE_NUM > 1) ? $clog2(CLAUSE_NUM) : 1;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t                state, state_n;
    logic [VAR_NUM-1:0]    mask [CLAUSE_NUM];
    logic [VAR_NUM-1:0]    pol  [CLAUSE_NUM];
    logic [CLAUSE_NUM-1:0] en_s;
    logic [VAR_NUM-1:0]    as_s, val_s;
    logic [CL_W-1:0]       idx;
    logic [1:0]            best_res;
    logic [VAR_W-1:0]      best_var;
    logic                  best_val;
    logic [CL_W-1:0]       best_idx;
    logic [VAR_NUM-1:0]    tru, free;
    logic [VAR_W-1:0]      fvar;
    logic                  conf, unit, last, early;
    always_comb begin
        tru  = mask[idx] & as_s & ~(val_s ^ pol[idx]);
        free = mask[idx] & ~as_s;
        conf = en_s[idx] & ~(|tru) & (free == '0);
        unit = en_s[idx] & ~(|tru) & (free != '0) & ((free & (free - VAR_NUM'(1))) == '0);
        last = idx == CL_W'(CLAUSE_NUM - 1);
        fvar = '0;
        for (int v = VAR_NUM - 1; v >= 0; v--)
            if (free[v]) fvar = VAR_W'(v);
    end
`ifdef BCP_SCAN_EARLY_EXIT_EN
    assign early = conf;
`else
    assign early = 1'b0;
`endif
    always_comb begin
        state_n = state;
        if (state == IDLE && bus.start) state_n = SCAN;
        else if (state == SCAN && (last || early)) state_n = DONE;
        else if (state == DONE) state_n = IDLE;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_n;
    assign bus.busy = state == SCAN;
    // Clause store: writable whenever no scan is reading it.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            for (int c = 0; c < CLAUSE_NUM; c++) begin
                mask[c] <= '0;
                pol[c]  <= '0;
            end
        end else if (bus.load_en && state != SCAN) begin
            mask[bus.load_addr] <= bus.load_mask;
            pol[bus.load_addr]  <= bus.load_pol;
        end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            en_s           <= '0;
            as_s           <= '0;
            val_s          <= '0;
            idx            <= '0;
            best_res       <= '0;
            best_var       <= '0;
            best_val       <= 1'b0;
            best_idx       <= '0;
            bus.done       <= 1'b0;
            bus.result     <= '0;
            bus.imp_var    <= '0;
            bus.imp_val    <= 1'b0;
            bus.clause_idx <= '0;
        end else begin
            bus.done <= state == DONE;
            if (state == IDLE && bus.start) begin
                en_s     <= bus.clause_en;
                as_s     <= bus.assigned;
                val_s    <= bus.value;
                idx      <= '0;
                best_res <= '0;
                best_var <= '0;
                best_val <= 1'b0;
                best_idx <= '0;
            end else if (state == SCAN) begin
                idx <= idx + CL_W'(1);
                // The first conflict always wins; a unit is kept only while nothing better exists.
                if (conf && best_res != 2'b10) begin
                    best_res <= 2'b10;
                    best_var <= '0;
                    best_val <= 1'b0;
                    best_idx <= idx;
                end else if (unit && best_res == 2'b00) begin
                    best_res <= 2'b01;
                    best_var <= fvar;
                    best_val <= pol[idx][fvar];
                    best_idx <= idx;
                end
            end else if (state == DONE) begin
                bus.result     <= best_res;
                bus.imp_var    <= best_var;
                bus.imp_val    <= best_val;
                bus.clause_idx <= best_idx;
            end
        end
endmodule

// File: tb/tb_bcp_scan_unit.sv
// tb_bcp_scan_unit: directed scans with a scoreboard queue checked by a done-driven monitor.
module tb_bcp_scan_unit;
`ifdef BCP_SCAN_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    typedef struct {
        string      tag;
        logic [1:0] res;
        int         v;
        logic       b;
        int         idx;
        int         at;
        bit         full;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t e_m;
    bcp_scan_if #(.VAR_NUM(8), .CLAUSE_NUM(8)) bus ();
    bcp_scan_unit #(.VAR_NUM(8), .CLAUSE_NUM(8)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask
    function automatic int clat(int k);
        return EE ? k + 2 : 9;
    endfunction
    always @(negedge clock)
        if (bus.done === 1'b1) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e_m = q.pop_front();
                chk({e_m.tag, ".result"}, bus.result, e_m.res);
                chk({e_m.tag, ".clause_idx"}, bus.clause_idx, e_m.idx);
                chk({e_m.tag, ".latency"}, cyc, e_m.at);
                if (e_m.full) begin
                    chk({e_m.tag, ".imp_var"}, bus.imp_var, e_m.v);
                    chk({e_m.tag, ".imp_val"}, bus.imp_val, e_m.b);
                end
            end
        end
    task automatic load(logic [2:0] a, logic [7:0] m, logic [7:0] p);
        @(negedge clock);
        bus.load_en = 1'b1;
        bus.load_addr = a;
        bus.load_mask = m;
        bus.load_pol = p;
        @(negedge clock);
        bus.load_en = 1'b0;
    endtask
    task automatic begin_scan(string tag, logic [7:0] en, logic [7:0] as, logic [7:0] vl,
                              logic [1:0] r, int v, logic b, int idx, int lat, bit full);
        @(negedge clock);
        bus.clause_en = en;
        bus.assigned = as;
        bus.value = vl;
        q.push_back('{tag, r, v, b, idx, cyc + 1 + lat, full});
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            chk("done_timeout", q.size(), 0);
            q.delete();
        end
    endtask
    task automatic scan(string tag, logic [7:0] en, logic [7:0] as, logic [7:0] vl,
                        logic [1:0] r, int v, logic b, int idx, int lat, bit full);
        begin_scan(tag, en, as, vl, r, v, b, idx, lat, full);
        wait_done();
    endtask
    initial begin
        bus.load_en = 1'b0;
        bus.load_addr = '0;
        bus.load_mask = '0;
        bus.load_pol = '0;
        bus.start = 1'b0;
        bus.clause_en = '0;
        bus.assigned = '0;
        bus.value = '0;
        repeat (2) @(negedge clock);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.result", bus.result, 0);
        chk("rst.imp_var", bus.imp_var, 0);
        chk("rst.imp_val", bus.imp_val, 0);
        chk("rst.clause_idx", bus.clause_idx, 0);
        reset = 1'b1;
        load(3'd0, 8'h03, 8'h01);
        scan("unit0", 8'h01, 8'h01, 8'h00, 2'b01, 1, 1'b0, 0, 9, 1'b1);
        load(3'd2, 8'h0C, 8'h0C);
        load(3'd4, 8'h30, 8'h10);
        scan("conf2", 8'h14, 8'hDF, 8'h00, 2'b10, 0, 1'b0, 2, clat(2), 1'b0);
        load(3'd1, 8'h03, 8'h03);
        load(3'd5, 8'hC0, 8'h00);
        scan("conf5", 8'h22, 8'hFD, 8'hC0, 2'b10, 0, 1'b0, 5, clat(5), 1'b0);
        scan("none_free", 8'h03, 8'h00, 8'h00, 2'b00, 0, 1'b0, 0, 9, 1'b1);
        scan("none_sat", 8'h03, 8'h01, 8'h01, 2'b00, 0, 1'b0, 0, 9, 1'b1);
        scan("unit_prio", 8'h03, 8'h01, 8'h00, 2'b01, 1, 1'b0, 0, 9, 1'b1);
        scan("conf_first", 8'h24, 8'hFF, 8'hC0, 2'b10, 0, 1'b0, 2, clat(2), 1'b0);
        scan("empty7", 8'h80, 8'h00, 8'h00, 2'b10, 0, 1'b0, 7, clat(7), 1'b0);
        scan("dis7", 8'h00, 8'h00, 8'h00, 2'b00, 0, 1'b0, 0, 9, 1'b1);
        // Mid-scan start and load must both be ignored.
        begin_scan("busy_start", 8'h01, 8'h01, 8'h00, 2'b01, 1, 1'b0, 0, 9, 1'b1);
        @(negedge clock);
        chk("busy_high", bus.busy, 1);
        bus.clause_en = 8'h80;
        bus.assigned = 8'h00;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.load_en = 1'b1;
        bus.load_addr = 3'd0;
        bus.load_mask = 8'h00;
        bus.load_pol = 8'h00;
        @(negedge clock);
        bus.load_en = 1'b0;
        wait_done();
        repeat (12) @(negedge clock);
        scan("readback", 8'h01, 8'h01, 8'h00, 2'b01, 1, 1'b0, 0, 9, 1'b1);
        // Reset in the third scan cycle: no done, outputs and store cleared.
        @(negedge clock);
        bus.clause_en = 8'h01;
        bus.assigned = 8'h01;
        bus.value = 8'h00;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst.busy", bus.busy, 0);
        chk("mid_rst.done", bus.done, 0);
        chk("mid_rst.result", bus.result, 0);
        chk("mid_rst.imp_var", bus.imp_var, 0);
        chk("mid_rst.clause_idx", bus.clause_idx, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        scan("cleared", 8'h01, 8'h00, 8'h00, 2'b10, 0, 1'b0, 0, clat(0), 1'b0);
        repeat (4) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
